// File: rtl/jk_counter_pkg.sv
// Shared JK action encoding and J/K decode helpers for the jk_counter slice.
package jk_counter_pkg;

    typedef enum logic [1:0] {
        JK_HOLD,
        JK_SET,
        JK_CLEAR,
        JK_TOGGLE
    } jk_action_e;

    // {J, K} pairs driven into a jk_bit for each action.
    localparam logic [1:0] JK_IN_HOLD   = 2'b00;
    localparam logic [1:0] JK_IN_SET    = 2'b10;
    localparam logic [1:0] JK_IN_CLEAR  = 2'b01;
    localparam logic [1:0] JK_IN_TOGGLE = 2'b11;

    // Loads force each bit explicitly; counting only toggles the bits that change.
    function automatic jk_action_e jk_action(input logic load, input logic cur, input logic nxt);
        if (load)
            return nxt ? JK_SET : JK_CLEAR;
        return (cur != nxt) ? JK_TOGGLE : JK_HOLD;
    endfunction

    function automatic logic [1:0] jk_decode(input jk_action_e action);
        case (action)
            JK_SET:    return JK_IN_SET;
            JK_CLEAR:  return JK_IN_CLEAR;
            JK_TOGGLE: return JK_IN_TOGGLE;
            default:   return JK_IN_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/jk_bit.sv
// Single JK storage cell with asynchronous active-low reset.
module jk_bit
    import jk_counter_pkg::*;
(
    input  logic CLK,
    input  logic Reset_n,
    input  logic J,
    input  logic K,
    output logic Q
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            Q <= 1'b0;
        end else begin
            case ({J, K})
                JK_IN_SET:    Q <= 1'b1;
                JK_IN_CLEAR:  Q <= 1'b0;
                JK_IN_TOGGLE: Q <= ~Q;
                default:      Q <= Q;
            endcase
        end
    end

endmodule

// File: rtl/jk_counter.sv
// Modulo up/down counter with parallel load, built from WIDTH JK cells.
module jk_counter
    import jk_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             Wrap
);

    localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] q_next;
    logic [1:0]       jk_vec [WIDTH];

    // NOTE: q_next gets a default before any branch so no latch is inferred.
    always_comb begin
        q_next = Q;
        if (Load) begin
            q_next = ({1'b0, D} >= MOD_EXT) ? Q_MAX : D;
        end else if (En) begin
            if (Up)
                q_next = (Q == Q_MAX) ? '0 : Q + 1'b1;
            else
                q_next = (Q == '0) ? Q_MAX : Q - 1'b1;
        end
    end

    always_comb begin
        jk_vec = '{default: JK_IN_HOLD};
        for (int i = 0; i < WIDTH; i++)
            jk_vec[i] = jk_decode(jk_action(Load, Q[i], q_next[i]));
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_bit u_jk_bit (
            .CLK     (CLK),
            .Reset_n (Reset_n),
            .J       (jk_vec[i][1]),
            .K       (jk_vec[i][0]),
            .Q       (Q[i])
        );
    end

    assign TC = En & ~Load & (Up ? (Q == Q_MAX) : (Q == '0));

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n)
            Wrap <= 1'b0;
        else
            Wrap <= TC;
    end

endmodule

// File: tb/tb_jk_counter.sv
// Self-checking bench: directed vector table, reset corners and random run vs a modulo model.
module tb_jk_counter;

    logic       CLK = 1'b0;
    logic       Reset_n = 1'b0;
    logic       En_a = 1'b0, Up_a = 1'b0, Load_a = 1'b0;
    logic [3:0] D_a = '0;
    logic [3:0] Q_a;
    logic       TC_a, Wrap_a;
    logic       En_b = 1'b0, Up_b = 1'b0, Load_b = 1'b0;
    logic [1:0] D_b = '0;
    logic [1:0] Q_b;
    logic       TC_b, Wrap_b;

    int checks = 0;
    int errors = 0;
    int qa_m = 0, wa_m = 0, qb_m = 0, wb_m = 0;

    typedef struct {
        bit load;
        bit en;
        bit up;
        int d;
        int exp_tc;
        int exp_q;
        int exp_wrap;
    } vec_t;

    vec_t vecs[$];

    jk_counter #(.WIDTH(4), .MODULUS(10)) dut_a (
        .CLK(CLK), .Reset_n(Reset_n), .En(En_a), .Up(Up_a), .Load(Load_a),
        .D(D_a), .Q(Q_a), .TC(TC_a), .Wrap(Wrap_a)
    );

    jk_counter #(.WIDTH(2), .MODULUS(2)) dut_b (
        .CLK(CLK), .Reset_n(Reset_n), .En(En_b), .Up(Up_b), .Load(Load_b),
        .D(D_b), .Q(Q_b), .TC(TC_b), .Wrap(Wrap_b)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    function automatic int model_next(int q, int m, bit load, bit en, bit up, int d);
        if (load) return (d >= m) ? m - 1 : d;
        if (!en)  return q;
        if (up)   return (q + 1) % m;
        return (q + m - 1) % m;
    endfunction

    function automatic int model_tc(int q, int m, bit load, bit en, bit up);
        return (en && !load && (up ? (q == m - 1) : (q == 0))) ? 1 : 0;
    endfunction

    // Inputs already applied; checks TC before the edge, Q/Wrap just after it.
    task automatic tick();
        int na, nb, ta, tb;
        #1;
        ta = model_tc(qa_m, 10, Load_a, En_a, Up_a);
        tb = model_tc(qb_m, 2, Load_b, En_b, Up_b);
        na = model_next(qa_m, 10, Load_a, En_a, Up_a, int'(D_a));
        nb = model_next(qb_m, 2, Load_b, En_b, Up_b, int'(D_b));
        check("tc_a", int'(TC_a), ta);
        check("tc_b", int'(TC_b), tb);
        @(posedge CLK);
        qa_m = na; wa_m = ta; qb_m = nb; wb_m = tb;
        #1;
        check("q_a", int'(Q_a), qa_m);
        check("wrap_a", int'(Wrap_a), wa_m);
        check("q_b", int'(Q_b), qb_m);
        check("wrap_b", int'(Wrap_b), wb_m);
    endtask

    initial begin
        for (int i = 1; i <= 12; i++)
            vecs.push_back('{1'b0, 1'b1, 1'b1, 0, (i == 10) ? 1 : 0, i % 10, (i == 10) ? 1 : 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 3,  0, 3, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 0,  0, 2, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 0,  0, 1, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 0,  0, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 0,  1, 9, 1});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 0,  0, 8, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 14, 0, 9, 0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 5,  0, 5, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 9,  0, 9, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 0,  0, 8, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 0,  0, 0, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 0,  0, 0, 0});

        // Reset held for two cycles; TC still decodes Q=0 counting down.
        En_a = 1'b1; Up_a = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_q_a", int'(Q_a), 0);
        check("rst_wrap_a", int'(Wrap_a), 0);
        check("rst_tc_a", int'(TC_a), 1);
        check("rst_q_b", int'(Q_b), 0);
        Up_a = 1'b1;
        Reset_n = 1'b1;

        foreach (vecs[i]) begin
            Load_a = vecs[i].load; En_a = vecs[i].en; Up_a = vecs[i].up; D_a = 4'(vecs[i].d);
            #1;
            check("vec_tc", int'(TC_a), vecs[i].exp_tc);
            tick();
            check("vec_q", int'(Q_a), vecs[i].exp_q);
            check("vec_wrap", int'(Wrap_a), vecs[i].exp_wrap);
        end

        // Asynchronous reset mid-count, then counting resumes from 0.
        Load_a = 1'b1; En_a = 1'b0; D_a = 4'd6;
        tick();
        check("mid_pre_q", int'(Q_a), 6);
        Load_a = 1'b0; En_a = 1'b1; Up_a = 1'b1;
        #3;
        Reset_n = 1'b0;
        #1;
        check("mid_rst_q", int'(Q_a), 0);
        check("mid_rst_wrap", int'(Wrap_a), 0);
        qa_m = 0; wa_m = 0; qb_m = 0; wb_m = 0;
        @(posedge CLK);
        #1;
        check("mid_rst_hold", int'(Q_a), 0);
        Reset_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("resume_q", int'(Q_a), i);
        end

        // MODULUS=2 continuous up-count: a wrap on every other edge.
        En_a = 1'b0;
        En_b = 1'b1; Up_b = 1'b1; Load_b = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("m2_q", int'(Q_b), i % 2);
            check("m2_wrap", int'(Wrap_b), (i % 2 == 0) ? 1 : 0);
            check("m2_range", (Q_b <= 2'd1) ? 1 : 0, 1);
        end

        for (int n = 0; n < 1000; n++) begin
            Load_a = ($urandom_range(0, 7) == 0);
            En_a   = ($urandom_range(0, 3) != 0);
            Up_a   = $urandom_range(0, 1) == 1;
            D_a    = 4'($urandom_range(0, 15));
            Load_b = ($urandom_range(0, 7) == 0);
            En_b   = ($urandom_range(0, 3) != 0);
            Up_b   = $urandom_range(0, 1) == 1;
            D_b    = 2'($urandom_range(0, 3));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jk_counter.md
JK_COUNTER -- requirements
Module: jk_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits, SHALL be >= 2.
REQ-002 Parameter MODULUS, default 2**WIDTH: count range 0..MODULUS-1, SHALL satisfy 2 <= MODULUS <= 2**WIDTH.
REQ-003 CLK  input  1: single clock; all state updates on its rising edge.
REQ-004 Reset_n  input  1: asynchronous, active-low reset.
REQ-005 En  input  1: count enable.
REQ-006 Up  input  1: direction; 1 = up, 0 = down.
REQ-007 Load  input  1: synchronous parallel load request.
REQ-008 D  input  WIDTH: parallel load value.
REQ-009 Q  output  WIDTH: current count, registered.
REQ-010 TC  output  1: terminal count, combinational.
REQ-011 Wrap  output  1: registered one-cycle pulse marking a wrap-around.

Function
REQ-012 Each Q bit SHALL be held in a JK storage cell whose J/K inputs are derived from the required next state: hold J=0,K=0; set J=1,K=0; clear J=0,K=1; toggle J=1,K=1.
REQ-013 Priority per rising edge: Load, then En, then hold.
REQ-014 With Load=1, Q SHALL become D, or MODULUS-1 when D >= MODULUS; Wrap SHALL be 0 that cycle; En and Up are ignored.
REQ-015 With Load=0, En=1, Up=1, Q SHALL become Q+1, except Q=MODULUS-1, which SHALL become 0.
REQ-016 With Load=0, En=1, Up=0, Q SHALL become Q-1, except Q=0, which SHALL become MODULUS-1.
REQ-017 With Load=0, En=0, Q and all JK cells SHALL hold.
REQ-018 TC SHALL be 1 exactly when En=1 and Load=0 and either Up=1 with Q=MODULUS-1 or Up=0 with Q=0.
REQ-019 Wrap SHALL be 1 for the single cycle after any edge at which TC was 1, and 0 otherwise.
REQ-020 Consecutive wraps (e.g. MODULUS=2 counting continuously) SHALL produce Wrap on every qualifying cycle, with no merging.
REQ-021 A direction change SHALL take effect at the same edge with no extra latency; Up toggling at a boundary SHALL follow REQ-015/016 for the sampled Up value.
REQ-022 Latency from input to Q SHALL be one clock; TC SHALL have zero latency from its inputs.
REQ-023 Q SHALL never hold a value >= MODULUS after any edge.

Reset
REQ-024 Reset_n=0 SHALL immediately force Q=0 and Wrap=0, regardless of CLK.
REQ-025 While Reset_n=0, Q and Wrap SHALL stay 0. TC SHALL follow REQ-018 with Q=0, so En=1, Up=0, Load=0 drives TC=1.
REQ-026 Reset asserted mid-count SHALL abort the operation, with no partial update. The first rising edge after deassertion SHALL act normally from Q=0.

Structure
REQ-027 A shared package SHALL hold the JK action encoding (HOLD, SET, CLEAR, TOGGLE) and the J/K decode constants.
REQ-028 Sub-module jk_bit SHALL implement one JK storage cell with CLK, asynchronous active-low Reset_n, J, K and Q. jk_counter SHALL instantiate WIDTH copies via generate.
REQ-029 Next-state, clamp and TC logic SHALL live in jk_counter. The Wrap register SHALL be a separate flop in jk_counter.

Verification (WIDTH=4, MODULUS=10)
REQ-030 Reset with Reset_n=0 for 2 cycles, then release with En=1, Up=1 for 12 edges -> Q sequence 1..9,0,1,2; TC=1 while Q=9; Wrap=1 only in the cycle where Q=0.
REQ-031 Load=1, D=3, then En=1, Up=0 for 5 edges -> Q=3,2,1,0,9,8; Wrap=1 only in the cycle where Q=9.
REQ-032 Load=1 with D=14 -> Q=9 (clamped). Load=1 with En=1, Up=1, D=5 -> Q=5, Wrap=0.
REQ-033 At Q=9 with Up=1, set Up=0 at the next edge -> Q=8, TC=0, Wrap=0. At Q=0, set Up=1 with En=0 -> Q holds 0.
REQ-034 Pull Reset_n low mid-cycle while Q=6 and En=1 -> Q=0 before the next CLK edge. Release -> counting resumes 1,2,....
REQ-035 With MODULUS=2, En=1, Up=1 for 6 edges -> Q alternates 1,0,...; Wrap=1 every other cycle; Q never exceeds 1. Random En/Up/Load stimulus vs a reference model for 1000 cycles -> no mismatches.
